// File: rtl/coin_acceptor.sv
// Coin intake for the vending datapath: accumulates quarters, dimes and nickels,
// vends at PRICE or refunds on cancel, and reports the returned amount on change.
module coin_acceptor #(
   parameter logic [6:0] PRICE = 7'd50
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       coin_q,
   input  logic       coin_d,
   input  logic       coin_n,
   input  logic       cancel,
   output logic [6:0] total,
   output logic       vend,
   output logic       refund,
   output logic       change_valid,
   output logic [6:0] change,
   output logic       reject
);

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      VEND,
      REFUND
   } state_t;

   state_t     state, state_next;
   logic [6:0] total_next;
   logic [6:0] change_next;
   logic       vend_next;
   logic       refund_next;
   logic       change_valid_next;
   logic       reject_next;

   logic       coin_any;
   logic       coin_single;
   logic       accept;
   logic [6:0] value;
   logic [6:0] sum;

   assign coin_any    = coin_q | coin_d | coin_n;
   assign coin_single = coin_any & ~((coin_q & coin_d) | (coin_q & coin_n) | (coin_d & coin_n));
   assign value       = coin_q ? 7'd25 : (coin_d ? 7'd10 : (coin_n ? 7'd5 : 7'd0));
   assign sum         = total + value;

   // Cancel takes priority over a coin in COLLECT, so that coin is rejected.
   assign accept = coin_single & en &
                   ((state == IDLE) | ((state == COLLECT) & ~cancel));

   always_comb begin
      state_next        = state;
      total_next        = total;
      change_next       = change;
      vend_next         = 1'b0;
      refund_next       = 1'b0;
      change_valid_next = 1'b0;
      reject_next       = coin_any & ~accept;

      case (state)
         IDLE, COLLECT: begin
            if ((state == COLLECT) && cancel) begin
               state_next        = REFUND;
               refund_next       = 1'b1;
               change_valid_next = 1'b1;
               change_next       = total;
            end else if (accept) begin
               total_next = sum;
               if (sum >= PRICE) begin
                  state_next        = VEND;
                  vend_next         = 1'b1;
                  change_valid_next = 1'b1;
                  change_next       = sum - PRICE;
               end else begin
                  state_next = COLLECT;
               end
            end
         end
         VEND, REFUND: begin
            state_next = IDLE;
            total_next = 7'd0;
         end
         default: begin
            state_next = IDLE;
            total_next = 7'd0;
         end
      endcase
   end

   // Pulses are registered alongside the state so they line up with VEND/REFUND.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         total        <= 7'd0;
         change       <= 7'd0;
         vend         <= 1'b0;
         refund       <= 1'b0;
         change_valid <= 1'b0;
         reject       <= 1'b0;
      end else begin
         state        <= state_next;
         total        <= total_next;
         change       <= change_next;
         vend         <= vend_next;
         refund       <= refund_next;
         change_valid <= change_valid_next;
         reject       <= reject_next;
      end
   end

endmodule

// File: tb/tb_coin_acceptor.sv
// Scoreboard bench for coin_acceptor at PRICE=50: each stimulus cycle pushes the
// outputs expected one edge later, which are popped and compared after that edge.
module tb_coin_acceptor;

   logic       clk;
   logic       reset;
   logic       en;
   logic       coin_q;
   logic       coin_d;
   logic       coin_n;
   logic       cancel;
   logic [6:0] total;
   logic       vend;
   logic       refund;
   logic       change_valid;
   logic [6:0] change;
   logic       reject;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [6:0] total;
      logic       vend;
      logic       refund;
      logic       change_valid;
      logic [6:0] change;
      logic       reject;
   } expect_t;

   expect_t scoreboard[$];

   coin_acceptor #(.PRICE(7'd50)) dut (
      .clk          (clk),
      .reset        (reset),
      .en           (en),
      .coin_q       (coin_q),
      .coin_d       (coin_d),
      .coin_n       (coin_n),
      .cancel       (cancel),
      .total        (total),
      .vend         (vend),
      .refund       (refund),
      .change_valid (change_valid),
      .change       (change),
      .reject       (reject)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [6:0] observed, input logic [6:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic checkAll(input string tag, input expect_t e);
      checkOutput({tag, ".total"},        total,                 e.total);
      checkOutput({tag, ".vend"},         {6'd0, vend},          {6'd0, e.vend});
      checkOutput({tag, ".refund"},       {6'd0, refund},        {6'd0, e.refund});
      checkOutput({tag, ".change_valid"}, {6'd0, change_valid},  {6'd0, e.change_valid});
      checkOutput({tag, ".change"},       change,                e.change);
      checkOutput({tag, ".reject"},       {6'd0, reject},        {6'd0, e.reject});
   endtask

   // Drive one cycle of inputs, expect the listed outputs after the next edge.
   task automatic applyStimulus(input string tag,
                                input logic q, input logic d, input logic n,
                                input logic c, input logic e_n,
                                input logic [6:0] exp_total, input logic exp_vend,
                                input logic exp_refund, input logic exp_cv,
                                input logic [6:0] exp_change, input logic exp_reject);
      expect_t e;
      expect_t got;
      e.total        = exp_total;
      e.vend         = exp_vend;
      e.refund       = exp_refund;
      e.change_valid = exp_cv;
      e.change       = exp_change;
      e.reject       = exp_reject;
      scoreboard.push_back(e);
      coin_q = q;
      coin_d = d;
      coin_n = n;
      cancel = c;
      en     = e_n;
      @(posedge clk);
      #1;
      coin_q = 1'b0;
      coin_d = 1'b0;
      coin_n = 1'b0;
      cancel = 1'b0;
      en     = 1'b1;
      if (scoreboard.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s.scoreboard: got empty queue, expected an entry", tag);
      end else begin
         got = scoreboard.pop_front();
         checkAll(tag, got);
      end
   endtask

   initial begin
      expect_t zero;
      zero = '{total: 7'd0, vend: 1'b0, refund: 1'b0, change_valid: 1'b0, change: 7'd0, reject: 1'b0};
      reset  = 1'b0;
      en     = 1'b1;
      coin_q = 1'b0;
      coin_d = 1'b0;
      coin_n = 1'b0;
      cancel = 1'b0;
      #12;
      checkAll("reset", zero);
      reset = 1'b1;

      //                         q  d  n  c  en tot vend ref cv chg rej
      applyStimulus("q1_a",     1, 0, 0, 0, 1, 25, 0, 0, 0,  0, 0);
      applyStimulus("q1_b",     1, 0, 0, 0, 1, 50, 1, 0, 1,  0, 0);
      applyStimulus("q1_idle",  0, 0, 0, 0, 1,  0, 0, 0, 0,  0, 0);

      applyStimulus("qddq_1",   1, 0, 0, 0, 1, 25, 0, 0, 0,  0, 0);
      applyStimulus("qddq_2",   0, 1, 0, 0, 1, 35, 0, 0, 0,  0, 0);
      applyStimulus("qddq_3",   0, 1, 0, 0, 1, 45, 0, 0, 0,  0, 0);
      applyStimulus("qddq_4",   1, 0, 0, 0, 1, 70, 1, 0, 1, 20, 0);
      applyStimulus("qddq_idle",0, 0, 0, 0, 1,  0, 0, 0, 0, 20, 0);

      applyStimulus("dnc_1",    0, 1, 0, 0, 1, 10, 0, 0, 0, 20, 0);
      applyStimulus("dnc_2",    0, 0, 1, 0, 1, 15, 0, 0, 0, 20, 0);
      applyStimulus("dnc_cxl",  0, 0, 0, 1, 1, 15, 0, 1, 1, 15, 0);
      applyStimulus("dnc_idle", 0, 0, 0, 0, 1,  0, 0, 0, 0, 15, 0);

      applyStimulus("idle_cxl", 0, 0, 0, 1, 1,  0, 0, 0, 0, 15, 0);
      applyStimulus("rej_qd",   1, 1, 0, 0, 1,  0, 0, 0, 0, 15, 1);
      applyStimulus("rej_en",   0, 0, 1, 0, 0,  0, 0, 0, 0, 15, 1);
      applyStimulus("rv_1",     1, 0, 0, 0, 1, 25, 0, 0, 0, 15, 0);
      applyStimulus("rv_2",     1, 0, 0, 0, 1, 50, 1, 0, 1,  0, 0);
      applyStimulus("rej_vend", 0, 0, 1, 1, 1,  0, 0, 0, 0,  0, 1);
      applyStimulus("rv_idle",  0, 0, 0, 0, 1,  0, 0, 0, 0,  0, 0);

      applyStimulus("qc_1",     1, 0, 0, 0, 1, 25, 0, 0, 0,  0, 0);
      applyStimulus("qc_ncxl",  0, 0, 1, 1, 1, 25, 0, 1, 1, 25, 1);
      applyStimulus("rej_rfnd", 0, 1, 0, 0, 1,  0, 0, 0, 0, 25, 1);
      applyStimulus("qc_idle",  0, 0, 0, 0, 1,  0, 0, 0, 0, 25, 0);

      applyStimulus("rs_1",     1, 0, 0, 0, 1, 25, 0, 0, 0, 25, 0);
      applyStimulus("rs_2",     0, 1, 0, 0, 1, 35, 0, 0, 0, 25, 0);
      applyStimulus("rs_3",     0, 0, 1, 0, 1, 40, 0, 0, 0, 25, 0);
      #3;
      reset = 1'b0;
      #1;
      checkAll("async_rst", zero);
      #2;
      reset = 1'b1;
      applyStimulus("rs_q",     1, 0, 0, 0, 1, 25, 0, 0, 0,  0, 0);
      applyStimulus("rs_d",     0, 1, 0, 0, 1, 35, 0, 0, 0,  0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
